// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, 3-sample mid-bit majority vote,
// optional parity check, and registered word/valid/error outputs per frame.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_reg, edge_cnt_next;
  logic [BIT_W-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [2:0]                samp_reg, samp_next;
  logic [DATA_WIDTH-1:0]     shadow_reg, shadow_next;
  logic                      par_flag_reg, par_flag_next;
  logic [PRESCALE_WIDTH-1:0] presc_reg, presc_next;
  logic                      par_en_reg, par_en_next;
  logic                      par_typ_reg, par_typ_next;
  logic [DATA_WIDTH-1:0]     p_data_reg, p_data_next;
  logic                      data_valid_reg, data_valid_next;
  logic                      par_err_reg, par_err_next;
  logic                      stp_err_reg, stp_err_next;

  logic [PRESCALE_WIDTH-1:0] half;
  logic                      bit_end;
  logic                      maj;
  logic                      stop_bad;

  assign half    = presc_reg >> 1;
  assign bit_end = (edge_cnt_reg == presc_reg - ONE);
  // Any two agreeing samples win, so a one-cycle spike on one sample is ignored.
  assign maj     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                   (samp_reg[1] & samp_reg[2]);
  assign stop_bad = ~maj;

  always_comb begin
    state_next      = state_reg;
    edge_cnt_next   = edge_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    samp_next       = samp_reg;
    shadow_next     = shadow_reg;
    par_flag_next   = par_flag_reg;
    presc_next      = presc_reg;
    par_en_next     = par_en_reg;
    par_typ_next    = par_typ_reg;
    p_data_next     = p_data_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    if (state_reg != IDLE) begin
      edge_cnt_next = bit_end ? '0 : edge_cnt_reg + ONE;
      if (edge_cnt_reg == half - ONE) samp_next[0] = RX_IN;
      if (edge_cnt_reg == half)       samp_next[1] = RX_IN;
      if (edge_cnt_reg == half + ONE) samp_next[2] = RX_IN;
    end

    case (state_reg)
      IDLE: begin
        if (!RX_IN) begin
          // The falling-edge cycle itself is edge 0 of the start bit.
          state_next    = START;
          edge_cnt_next = ONE;
          bit_cnt_next  = '0;
          par_flag_next = 1'b0;
          presc_next    = Prescale;
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
        end
      end
      START: begin
        if (bit_end) state_next = maj ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shadow_next[bit_cnt_reg] = maj;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (maj != ((^shadow_reg) ^ par_typ_reg)) par_flag_next = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          if (par_flag_reg || stop_bad) begin
            par_err_next = par_flag_reg;
            stp_err_next = stop_bad;
          end else begin
            data_valid_next = 1'b1;
            p_data_next     = shadow_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      edge_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      samp_reg       <= '0;
      shadow_reg     <= '0;
      par_flag_reg   <= 1'b0;
      presc_reg      <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      edge_cnt_reg   <= edge_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      samp_reg       <= samp_next;
      shadow_reg     <= shadow_next;
      par_flag_reg   <= par_flag_next;
      presc_reg      <= presc_next;
      par_en_reg     <= par_en_next;
      par_typ_reg    <= par_typ_next;
      p_data_reg     <= p_data_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
    end
  end

  assign P_DATA     = p_data_reg;
  assign data_valid = data_valid_reg;
  assign par_err    = par_err_reg;
  assign stp_err    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_seen = 0, pe_seen = 0, se_seen = 0;
  int exp_dv = 0, exp_pe = 0, exp_se = 0;
  int last_dv = 0, prev_dv = 0;
  logic [7:0] model_pdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every output pulse and timestamps valid pulses.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_seen <= dv_seen + 1;
      prev_dv <= last_dv;
      last_dv <= cyc;
    end
    if (par_err) pe_seen <= pe_seen + 1;
    if (stp_err) se_seen <= se_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive_cycle(input logic v);
    RX_IN = v;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; stop_after >= 0 aborts after that many cycles.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input int presc, input logic bad_par, input logic stop_v,
                            input int spike_bit, input int stop_after);
    logic fb [0:10];
    int   nbits;
    int   ci;
    logic v;
    nbits = 10 + int'(pe);
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    if (pe) fb[9] = (^d) ^ pt ^ bad_par;
    fb[nbits-1] = stop_v;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = 6'(presc);
    ci = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int e = 0; e < presc; e++) begin
        if (stop_after >= 0 && ci == stop_after) return;
        v = fb[b];
        if (b >= 1 && b <= 8 && (b - 1) == spike_bit && e == presc / 2) v = ~v;
        if (ci == 1) begin
          // Configuration must be latched at start detect, so scramble it.
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
          Prescale = 6'($urandom);
        end
        drive_cycle(v);
        ci++;
      end
    end
  endtask

  // Sends a full frame and checks the outputs in cycle N*Prescale.
  task automatic frame_check(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input int presc, input logic bad_par,
                             input logic stop_v, input int spike_bit);
    logic e_pe, e_se, good;
    send_frame(d, pe, pt, presc, bad_par, stop_v, spike_bit, -1);
    e_pe = pe & bad_par;
    e_se = ~stop_v;
    good = ~e_pe & ~e_se;
    if (good) begin
      model_pdata = d;
      exp_dv++;
    end
    if (e_pe) exp_pe++;
    if (e_se) exp_se++;
    check_eq({tag, ".dv"}, 32'(data_valid), 32'(good));
    check_eq({tag, ".par_err"}, 32'(par_err), 32'(e_pe));
    check_eq({tag, ".stp_err"}, 32'(stp_err), 32'(e_se));
    check_eq({tag, ".pdata"}, 32'(P_DATA), 32'(model_pdata));
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, ".dv_cnt"}, 32'(dv_seen), 32'(exp_dv));
    check_eq({tag, ".pe_cnt"}, 32'(pe_seen), 32'(exp_pe));
    check_eq({tag, ".se_cnt"}, 32'(se_seen), 32'(exp_se));
  endtask

  initial begin
    rst = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.pdata", 32'(P_DATA), 32'h0);
    check_eq("reset.flags", {29'h0, data_valid, par_err, stp_err}, 32'h0);
    rst = 1'b1;
    repeat (4) drive_cycle(1'b1);

    frame_check("a5_good", 8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1, -1);
    drive_cycle(1'b1);
    check_eq("a5_good.pulse_width", {29'h0, data_valid, par_err, stp_err}, 32'h0);
    frame_check("a5_badpar", 8'hA5, 1'b1, 1'b0, 8, 1'b1, 1'b1, -1);
    drive_cycle(1'b1);
    frame_check("3c_badstop", 8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0, -1);
    drive_cycle(1'b1);
    frame_check("3c_good", 8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b1, -1);
    drive_cycle(1'b1);

    // Start-bit glitch: three low cycles must not produce any frame.
    Prescale = 6'd8;
    repeat (3) drive_cycle(1'b0);
    repeat (10) drive_cycle(1'b1);
    check_counts("glitch");
    frame_check("5a_after_glitch", 8'h5A, 1'b0, 1'b0, 8, 1'b0, 1'b1, -1);

    // Back-to-back frames with no idle gap.
    frame_check("b2b_00", 8'h00, 1'b1, 1'b1, 32, 1'b0, 1'b1, -1);
    frame_check("b2b_ff", 8'hFF, 1'b1, 1'b1, 32, 1'b0, 1'b1, -1);
    check_eq("b2b.spacing", 32'(last_dv - prev_dv), 32'd352);
    drive_cycle(1'b1);

    frame_check("spike", 8'h96, 1'b1, 1'b0, 16, 1'b0, 1'b1, 3);
    drive_cycle(1'b1);

    // Reset in the middle of the data bits discards the frame.
    send_frame(8'h33, 1'b0, 1'b0, 8, 1'b0, 1'b1, -1, 8 * 4);
    #3 rst = 1'b0;
    #1;
    check_eq("midrst.pdata", 32'(P_DATA), 32'h0);
    check_eq("midrst.flags", {29'h0, data_valid, par_err, stp_err}, 32'h0);
    model_pdata = 8'h00;
    RX_IN = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) drive_cycle(1'b1);
    frame_check("after_rst", 8'hC3, 1'b1, 1'b1, 8, 1'b0, 1'b1, -1);

    for (int n = 0; n < 20; n++) begin
      int   presc;
      int   sel;
      logic [7:0] d;
      sel   = $urandom_range(0, 2);
      presc = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
      d     = 8'($urandom);
      frame_check($sformatf("rnd%0d", n), d, 1'($urandom), 1'($urandom), presc,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) drive_cycle(1'b1);
    end
    repeat (4) drive_cycle(1'b1);
    check_counts("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path; the counterpart of the existing UART TX chain (serializer, parity, start/stop output mux).
- Deserializes one frame from the serial line RX_IN, LSB first, with configurable parity and oversampling.
- Decides each bit by a 3-sample majority vote around mid-bit.
- Delivers the parallel byte plus a one-cycle valid pulse to the system FIFO/controller. Parity and stop-bit errors are flagged.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input (oversampling ratio).

Ports:
- clk  input  1  receive oversampling clock.
- rst  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idle high; already synchronized to clk upstream.
- PAR_EN  input  1  1 = parity bit present in frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32; others undefined.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse, P_DATA updated.
- par_err  output  1  one-cycle pulse, parity mismatch.
- stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (rst=0, async):
  - State returns to IDLE.
  - All counters are cleared.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - A frame in progress is discarded, with no output pulse.
- Configuration: PAR_EN, PAR_TYP and Prescale are latched on the start-detect cycle. Changes mid-frame are ignored until the next frame.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit.
  - bit_cnt indexes data bits 0..DATA_WIDTH-1.
- Sampling:
  - RX_IN is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the majority of the 3 samples, used at edge_cnt = Prescale-1.
- States:
  - IDLE:
    - RX_IN=1 -> stay.
    - RX_IN=0 -> START. That cycle is edge_cnt 0 of the start bit (cycle 0 of the frame).
  - START:
    - At end of bit, sampled 1 (glitch) -> IDLE, no outputs, no error.
    - Sampled 0 -> DATA.
  - DATA:
    - Each bit-end shifts the sampled bit into P_DATA-shadow position bit_cnt (LSB first).
    - After DATA_WIDTH bits -> PARITY if latched PAR_EN=1, else STOP.
  - PARITY:
    - Expected bit = XOR of data bits when PAR_TYP=0; its inverse when PAR_TYP=1.
    - A mismatch sets an internal parity-error flag.
    - -> STOP.
  - STOP:
    - At end of bit, if sampled 0, set the internal stop-error flag.
    - -> IDLE unconditionally.
    - The next falling edge is accepted from the very next cycle (back-to-back frames).
- Output timing:
  - N = 2 + DATA_WIDTH + PAR_EN bits per frame.
  - Outputs are registered and update in cycle N*Prescale relative to cycle 0, i.e. the clk after stop-bit edge_cnt = Prescale-1.
- No errors: P_DATA <= shadow, data_valid=1 for exactly 1 cycle.
- Any error:
  - par_err and/or stp_err pulse for 1 cycle (both if both occur).
  - data_valid stays 0.
  - P_DATA holds its previous value.
- Outputs other than P_DATA are 0 in every other cycle. P_DATA is stable between valid pulses.
- A single-cycle spike on any one of the three mid-bit samples must not change the decided bit.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> data_valid=1 for one cycle at cycle 88, P_DATA=0xA5, par_err=0, stp_err=0.
- Same frame with parity bit driven 1 -> par_err=1 for one cycle at cycle 88, data_valid=0, P_DATA keeps 0xA5 from the prior frame.
- Prescale=16, PAR_EN=0, frame 0x3C with stop bit 0 -> stp_err pulse at cycle 160, data_valid=0. A following good 0x3C frame is accepted normally.
- Glitch: RX_IN low for 3 cycles then high, Prescale=8 -> returns to IDLE, no pulses. A valid 0x5A frame immediately after gives P_DATA=0x5A.
- Back-to-back, Prescale=32, PAR_EN=1, PAR_TYP=1: frames 0x00 then 0xFF with no idle gap -> two data_valid pulses 352 cycles apart, P_DATA=0x00 then 0xFF.
- Robustness and reset:
  - Inject a 1-cycle inverted spike at sample Prescale/2 of a data bit -> byte still correct.
  - Assert rst mid-DATA -> all outputs 0 immediately. The next full frame is received correctly.
